llc_mem_beat_adapter: RTL and testbench
=======================================

LLC_MEM_BEAT_ADAPTER -- requirements
Module: llc_mem_beat_adapter

Interface
REQ-001 SHALL have parameter WORDS_PER_LINE, default 4, words per cache line (power of 2, >=2).
REQ-002 SHALL have parameter WORD_BITS, default 64, bits per word; LINE_BITS = WORDS_PER_LINE*WORD_BITS.
REQ-003 SHALL have parameter LINE_ADDR_BITS, default 28, line-address width; OFF_BITS = log2(WORDS_PER_LINE*WORD_BITS/8).
REQ-004 SHALL have port clk, in, 1, sole clock, rising edge.
REQ-005 SHALL have port rst, in, 1, asynchronous active-high reset.
REQ-006 SHALL have ports llc_mem_req_valid in 1 and llc_mem_req_ready out 1, line request handshake from LLC core.
REQ-007 SHALL have ports llc_mem_req_data_hwrite in 1, llc_mem_req_data_hsize in 3 (ignored), llc_mem_req_data_hprot in 2, llc_mem_req_data_addr in LINE_ADDR_BITS, llc_mem_req_data_line in LINE_BITS.
REQ-008 SHALL have ports llc_mem_rsp_valid out 1, llc_mem_rsp_ready in 1, llc_mem_rsp_data_line out LINE_BITS, read-line response to LLC core.
REQ-009 SHALL have ports mem_beat_valid out 1, mem_beat_ready in 1, mem_beat_write out 1, mem_beat_addr out LINE_ADDR_BITS+OFF_BITS (byte address), mem_beat_wdata out WORD_BITS, mem_beat_hprot out 2, word-beat request to memory.
REQ-010 SHALL have ports mem_rdata_valid in 1, mem_rdata_ready out 1, mem_rdata in WORD_BITS, in-order read data from memory.
REQ-011 SHALL have ports llc_mem_rd_cnt out 32 and llc_mem_wr_cnt out 32, line transaction counters.

Function
REQ-012 SHALL implement FSM states IDLE, WR_BEAT, RD_REQ, RD_DATA, RSP.
REQ-013 IDLE SHALL assert llc_mem_req_ready; on valid&ready it SHALL latch addr, line, hprot, hwrite, clear beat index and data index, go to WR_BEAT if hwrite else RD_REQ.
REQ-014 llc_mem_req_ready SHALL be 0 in every state except IDLE.
REQ-015 In WR_BEAT and RD_REQ mem_beat_valid SHALL be 1, mem_beat_write = latched hwrite, mem_beat_hprot = latched hprot, mem_beat_addr = {line addr, beat index, zero byte bits}.
REQ-016 mem_beat_wdata SHALL be line word [beat index] (word 0 = bits WORD_BITS-1:0); 0 during reads.
REQ-017 Beat index SHALL increment only on mem_beat_valid&mem_beat_ready; address and data SHALL stay stable while valid and not ready.
REQ-018 WR_BEAT SHALL return to IDLE on acceptance of beat WORDS_PER_LINE-1; writes produce no llc_mem_rsp.
REQ-019 RD_REQ SHALL go to RD_DATA on acceptance of beat WORDS_PER_LINE-1.
REQ-020 mem_rdata_ready SHALL be 1 in RD_REQ and RD_DATA, 0 otherwise; each mem_rdata_valid&ready SHALL store mem_rdata into line word [data index] and increment data index.
REQ-021 Data acceptance SHALL proceed concurrently with beat issue in RD_REQ; if the last beat and the last data word are accepted in the same cycle the FSM SHALL go directly to RSP.
REQ-022 RD_DATA SHALL go to RSP on acceptance of data word WORDS_PER_LINE-1.
REQ-023 RSP SHALL hold llc_mem_rsp_valid=1 with stable llc_mem_rsp_data_line until llc_mem_rsp_ready, then go to IDLE; new request acceptance SHALL begin no earlier than the following cycle.
REQ-024 Index counters SHALL be log2(WORDS_PER_LINE) bits and wrap to 0 after the last word.
REQ-025 mem_rdata_valid outside RD_REQ/RD_DATA SHALL be ignored with no state change.
REQ-026 Minimum latency: write line = WORDS_PER_LINE+1 cycles request-to-IDLE; read line with zero-wait memory = WORDS_PER_LINE+2 cycles request-to-rsp_valid.

Reset
REQ-027 rst SHALL asynchronously force FSM to IDLE, clear indices, latched line/addr, counters, and all outputs to 0 except llc_mem_req_ready, which SHALL be 1 after rst deasserts.
REQ-028 rst mid-transaction SHALL abort it; no residual beat or response SHALL be issued afterwards.

Configuration
REQ-029 With macro LLC_MEM_STATS_EN defined, llc_mem_rd_cnt SHALL increment on each RSP handshake and llc_mem_wr_cnt on each completed write line, both wrapping at 2^32.
REQ-030 Without LLC_MEM_STATS_EN, both counter outputs SHALL be constant 0 and no counter registers SHALL be synthesized.

Verification
REQ-031 Write addr 0x0000010, line words {A,B,C,D}, mem_beat_ready=1 -> beats at byte addr 0x200,0x208,0x210,0x218 with data A,B,C,D, write=1, no rsp.
REQ-032 Read addr 0x0000001, memory returns 0x11,0x22,0x33,0x44 one cycle after each beat -> rsp line {0x44,0x33,0x22,0x11} (word 3..0), rsp_valid cycle 6 after request.
REQ-033 Read with mem_beat_ready toggling 1,0,1,0 and llc_mem_rsp_ready held 0 for 5 cycles -> beat addr/data stable during stalls, rsp_valid and line stable until ready, then IDLE.
REQ-034 rst pulsed after second write beat accepted -> no further beats, llc_mem_req_ready=1 after rst, next read completes correctly.
REQ-035 With LLC_MEM_STATS_EN: 3 writes then 2 reads -> wr_cnt=3, rd_cnt=2; without macro both read 0.
REQ-036 Spurious mem_rdata_valid=1 in IDLE with data 0xDEAD -> ignored, next read line contains no 0xDEAD.

Source files
------------

// File: rtl/llc_mem_beat_adapter.sv
// ---------------------------------------------------------------------------
// llc_mem_beat_adapter
//
// Purpose: turns one cache-line request from the LLC core into a sequence of
// word-wide beats towards memory. A write line is sent as WORDS_PER_LINE
// write beats and produces no response. A read line is sent as
// WORDS_PER_LINE read beats. The in-order read data is collected back into a
// line and returned on the llc_mem_rsp channel.
//
// Ports:
//   clk, rst                 clock (rising edge) and async active-high reset
//   llc_mem_req_*            line request from the LLC core (valid/ready);
//                            hsize is accepted but has no effect
//   llc_mem_rsp_*            read-line response to the LLC core (valid/ready)
//   mem_beat_*               word-beat request to memory (valid/ready);
//                            addr is a byte address
//   mem_rdata_*              in-order read data from memory (valid/ready)
//   llc_mem_rd_cnt/_wr_cnt   completed read/write line counters
//
// Configuration:
//   LLC_MEM_STATS_EN         when defined, the two line counters are built.
//                            Otherwise the counter outputs are tied to 0.
//
// WORD_BITS is assumed to be a power of two of at least 16, so that each
// beat address has at least one zero byte-offset bit.
// ---------------------------------------------------------------------------
module llc_mem_beat_adapter #(
    parameter int WORDS_PER_LINE = 4,
    parameter int WORD_BITS      = 64,
    parameter int LINE_ADDR_BITS = 28,
    localparam int LINE_BITS     = WORDS_PER_LINE * WORD_BITS,
    localparam int OFF_BITS      = $clog2(LINE_BITS / 8)
) (
    input  logic                               clk,
    input  logic                               rst,

    input  logic                               llc_mem_req_valid,
    output logic                               llc_mem_req_ready,
    input  logic                               llc_mem_req_data_hwrite,
    input  logic [2:0]                         llc_mem_req_data_hsize,
    input  logic [1:0]                         llc_mem_req_data_hprot,
    input  logic [LINE_ADDR_BITS-1:0]          llc_mem_req_data_addr,
    input  logic [LINE_BITS-1:0]               llc_mem_req_data_line,

    output logic                               llc_mem_rsp_valid,
    input  logic                               llc_mem_rsp_ready,
    output logic [LINE_BITS-1:0]               llc_mem_rsp_data_line,

    output logic                               mem_beat_valid,
    input  logic                               mem_beat_ready,
    output logic                               mem_beat_write,
    output logic [LINE_ADDR_BITS+OFF_BITS-1:0] mem_beat_addr,
    output logic [WORD_BITS-1:0]               mem_beat_wdata,
    output logic [1:0]                         mem_beat_hprot,

    input  logic                               mem_rdata_valid,
    output logic                               mem_rdata_ready,
    input  logic [WORD_BITS-1:0]               mem_rdata,

    output logic [31:0]                        llc_mem_rd_cnt,
    output logic [31:0]                        llc_mem_wr_cnt
);

    localparam int BEAT_BITS = $clog2(WORDS_PER_LINE);
    localparam int BYTE_BITS = $clog2(WORD_BITS / 8);
    localparam logic [BEAT_BITS-1:0] LAST_IDX = BEAT_BITS'(WORDS_PER_LINE - 1);

    typedef enum logic [2:0] {
        IDLE,
        WR_BEAT,
        RD_REQ,
        RD_DATA,
        RSP
    } state_t;

    state_t                                    state;
    logic [BEAT_BITS-1:0]                      beat_idx;
    logic [BEAT_BITS-1:0]                      data_idx;
    logic [LINE_ADDR_BITS-1:0]                 addr_q;
    logic [WORDS_PER_LINE-1:0][WORD_BITS-1:0]  line_q;
    logic [1:0]                                hprot_q;
    logic                                      hwrite_q;

    logic beat_hs;
    logic rdata_hs;
    logic beat_last;
    logic data_last;

    // hsize has no effect on a whole-line transfer.
    logic unused_hsize;
    assign unused_hsize = ^llc_mem_req_data_hsize;

    // Handshake strobes. The valid/ready outputs are decoded from the state
    // register alone, so no input combinationally reaches them.
    assign beat_hs   = mem_beat_valid & mem_beat_ready;
    assign rdata_hs  = mem_rdata_valid & mem_rdata_ready;
    assign beat_last = (beat_idx == LAST_IDX);
    assign data_last = (data_idx == LAST_IDX);

    assign llc_mem_req_ready = (state == IDLE);
    assign mem_beat_valid    = (state == WR_BEAT) || (state == RD_REQ);
    assign mem_rdata_ready   = (state == RD_REQ) || (state == RD_DATA);
    assign llc_mem_rsp_valid = (state == RSP);

    // Beat fields are driven only while a beat is offered. Each field comes
    // from registers that do not change until the beat is accepted, so it is
    // stable across stalls.
    assign mem_beat_write = mem_beat_valid & hwrite_q;
    assign mem_beat_hprot = mem_beat_valid ? hprot_q : 2'b00;
    assign mem_beat_addr  = mem_beat_valid ? {addr_q, beat_idx, {BYTE_BITS{1'b0}}} : '0;
    assign mem_beat_wdata = (state == WR_BEAT) ? line_q[beat_idx] : '0;

    assign llc_mem_rsp_data_line = llc_mem_rsp_valid ? line_q : '0;

    // NOTE: sequential state uses non-blocking assignments only. Every
    // register sees the pre-edge value of every other register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the line buffer is cleared on reset together with the
            // control state. A response can then never expose stale data.
            state    <= IDLE;
            beat_idx <= '0;
            data_idx <= '0;
            addr_q   <= '0;
            line_q   <= '0;
            hprot_q  <= '0;
            hwrite_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (llc_mem_req_valid) begin
                        addr_q   <= llc_mem_req_data_addr;
                        line_q   <= llc_mem_req_data_line;
                        hprot_q  <= llc_mem_req_data_hprot;
                        hwrite_q <= llc_mem_req_data_hwrite;
                        beat_idx <= '0;
                        data_idx <= '0;
                        state    <= llc_mem_req_data_hwrite ? WR_BEAT : RD_REQ;
                    end
                end

                WR_BEAT: begin
                    if (beat_hs) begin
                        beat_idx <= beat_idx + 1'b1;
                        if (beat_last) state <= IDLE;
                    end
                end

                RD_REQ: begin
                    // Read data may already stream back while later beats are
                    // still being issued.
                    if (beat_hs) beat_idx <= beat_idx + 1'b1;
                    if (rdata_hs) begin
                        line_q[data_idx] <= mem_rdata;
                        data_idx         <= data_idx + 1'b1;
                    end
                    if (beat_hs && beat_last)
                        state <= (rdata_hs && data_last) ? RSP : RD_DATA;
                end

                RD_DATA: begin
                    if (rdata_hs) begin
                        line_q[data_idx] <= mem_rdata;
                        data_idx         <= data_idx + 1'b1;
                        if (data_last) state <= RSP;
                    end
                end

                RSP: begin
                    if (llc_mem_rsp_ready) state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

`ifdef LLC_MEM_STATS_EN
    logic [31:0] rd_cnt_q;
    logic [31:0] wr_cnt_q;

    // Both counters wrap naturally at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            if (llc_mem_rsp_valid && llc_mem_rsp_ready)
                rd_cnt_q <= rd_cnt_q + 32'd1;
            if ((state == WR_BEAT) && beat_hs && beat_last)
                wr_cnt_q <= wr_cnt_q + 32'd1;
        end
    end

    assign llc_mem_rd_cnt = rd_cnt_q;
    assign llc_mem_wr_cnt = wr_cnt_q;
`else
    assign llc_mem_rd_cnt = 32'd0;
    assign llc_mem_wr_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_llc_mem_beat_adapter.sv
// ---------------------------------------------------------------------------
// tb_llc_mem_beat_adapter
//
// Scoreboard bench for llc_mem_beat_adapter with default parameters.
// The stimulus pushes expected beats and response lines. These are derived
// from a word-addressed reference memory. A monitor compares every offered
// beat and response against the head of its queue. A behavioural memory
// serves the DUT's beats.
// ---------------------------------------------------------------------------
module tb_llc_mem_beat_adapter;

    localparam int W  = 4;
    localparam int WB = 64;
`ifdef LLC_MEM_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic         llc_mem_req_valid;
    logic         llc_mem_req_ready;
    logic         llc_mem_req_data_hwrite;
    logic [2:0]   llc_mem_req_data_hsize;
    logic [1:0]   llc_mem_req_data_hprot;
    logic [27:0]  llc_mem_req_data_addr;
    logic [255:0] llc_mem_req_data_line;
    logic         llc_mem_rsp_valid;
    logic         llc_mem_rsp_ready;
    logic [255:0] llc_mem_rsp_data_line;
    logic         mem_beat_valid;
    logic         mem_beat_ready;
    logic         mem_beat_write;
    logic [32:0]  mem_beat_addr;
    logic [63:0]  mem_beat_wdata;
    logic [1:0]   mem_beat_hprot;
    logic         mem_rdata_valid;
    logic         mem_rdata_ready;
    logic [63:0]  mem_rdata;
    logic [31:0]  llc_mem_rd_cnt;
    logic [31:0]  llc_mem_wr_cnt;

    llc_mem_beat_adapter dut (
        .clk                     (clk),
        .rst                     (rst),
        .llc_mem_req_valid       (llc_mem_req_valid),
        .llc_mem_req_ready       (llc_mem_req_ready),
        .llc_mem_req_data_hwrite (llc_mem_req_data_hwrite),
        .llc_mem_req_data_hsize  (llc_mem_req_data_hsize),
        .llc_mem_req_data_hprot  (llc_mem_req_data_hprot),
        .llc_mem_req_data_addr   (llc_mem_req_data_addr),
        .llc_mem_req_data_line   (llc_mem_req_data_line),
        .llc_mem_rsp_valid       (llc_mem_rsp_valid),
        .llc_mem_rsp_ready       (llc_mem_rsp_ready),
        .llc_mem_rsp_data_line   (llc_mem_rsp_data_line),
        .mem_beat_valid          (mem_beat_valid),
        .mem_beat_ready          (mem_beat_ready),
        .mem_beat_write          (mem_beat_write),
        .mem_beat_addr           (mem_beat_addr),
        .mem_beat_wdata          (mem_beat_wdata),
        .mem_beat_hprot          (mem_beat_hprot),
        .mem_rdata_valid         (mem_rdata_valid),
        .mem_rdata_ready         (mem_rdata_ready),
        .mem_rdata               (mem_rdata),
        .llc_mem_rd_cnt          (llc_mem_rd_cnt),
        .llc_mem_wr_cnt          (llc_mem_wr_cnt)
    );

    typedef struct {
        logic [32:0] addr;
        logic [63:0] data;
        logic        wr;
        logic [1:0]  hprot;
    } beat_t;

    beat_t        exp_beat_q[$];
    logic [255:0] exp_rsp_q[$];
    int unsigned  rd_q[$];
    logic [63:0]  mem     [int unsigned];
    logic [63:0]  ref_mem [int unsigned];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int req_cycle;
    int beat_hs_cnt = 0;
    int wr_model = 0;
    int rd_model = 0;
    int beat_mode = 0;   // 0: always ready, 1: random, 2: toggle
    bit rand_mode = 0;
    bit spur      = 0;
    bit tog       = 0;
    int rsp_hold  = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] init_word(input int unsigned a);
        return {32'hC0DE0000 + a, 32'h5A5A0000 ^ a};
    endfunction

    function automatic logic [63:0] mem_rd(input int unsigned a);
        return mem.exists(a) ? mem[a] : init_word(a);
    endfunction

    function automatic logic [63:0] ref_rd(input int unsigned a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=%0d required=finished", cyc);
        $fatal(1, "simulation time limit");
    end

    // Monitor. A beat or response that is offered is compared with the head
    // of its queue in every cycle. This covers stability during stalls, and
    // the entry is consumed on handshake.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (mem_beat_valid) begin
                if (exp_beat_q.size() == 0) begin
                    check("unexpected_beat", {223'd0, mem_beat_addr}, 256'd0);
                end else begin
                    check("beat_addr",  mem_beat_addr,  exp_beat_q[0].addr);
                    check("beat_wdata", mem_beat_wdata, exp_beat_q[0].data);
                    check("beat_write", mem_beat_write, exp_beat_q[0].wr);
                    check("beat_hprot", mem_beat_hprot, exp_beat_q[0].hprot);
                    if (mem_beat_ready) begin
                        void'(exp_beat_q.pop_front());
                        beat_hs_cnt++;
                    end
                end
            end
            if (llc_mem_rsp_valid) begin
                if (exp_rsp_q.size() == 0) begin
                    check("unexpected_rsp", llc_mem_rsp_data_line, 256'd0);
                end else begin
                    check("rsp_line", llc_mem_rsp_data_line, exp_rsp_q[0]);
                    if (llc_mem_rsp_ready) void'(exp_rsp_q.pop_front());
                end
            end
        end
    end

    // Memory side and response-ready driver.
    initial begin
        mem_beat_ready    = 1'b0;
        mem_rdata_valid   = 1'b0;
        mem_rdata         = '0;
        llc_mem_rsp_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (mem_rdata_valid && mem_rdata_ready && !spur && rd_q.size() > 0)
                    void'(rd_q.pop_front());
                if (mem_beat_valid && mem_beat_ready) begin
                    if (mem_beat_write) mem[32'(mem_beat_addr >> 3)] = mem_beat_wdata;
                    else                rd_q.push_back(32'(mem_beat_addr >> 3));
                end
            end
            @(posedge clk);
            #1;
            tog = ~tog;
            if (rst) begin
                mem_beat_ready    = 1'b0;
                mem_rdata_valid   = 1'b0;
                llc_mem_rsp_ready = 1'b0;
                rd_q.delete();
            end else begin
                case (beat_mode)
                    0:       mem_beat_ready = 1'b1;
                    1:       mem_beat_ready = ($urandom % 4) != 0;
                    default: mem_beat_ready = tog;
                endcase
                if (spur) begin
                    mem_rdata_valid = 1'b1;
                    mem_rdata       = 64'hDEAD;
                end else if (rd_q.size() > 0 && (!rand_mode || ($urandom % 3) != 0)) begin
                    mem_rdata_valid = 1'b1;
                    mem_rdata       = mem_rd(rd_q[0]);
                end else begin
                    mem_rdata_valid = 1'b0;
                    mem_rdata       = {$urandom, $urandom};
                end
                if (rsp_hold > 0 && llc_mem_rsp_valid) begin
                    llc_mem_rsp_ready = 1'b0;
                    rsp_hold--;
                end else begin
                    llc_mem_rsp_ready = rand_mode ? 1'($urandom % 2) : 1'b1;
                end
            end
        end
    end

    // Queue the expected traffic of one line request, then present it until
    // it is accepted. commit < W models a write cut short by reset.
    task automatic do_req(input bit wr, input int unsigned la, input logic [255:0] line,
                          input logic [1:0] hp, input int commit);
        beat_t        b;
        logic [255:0] rl;
        bit           ok;
        for (int i = 0; i < W; i++) begin
            b.addr  = 33'((la * W + i) * 8);
            b.data  = wr ? line[i*WB +: WB] : 64'd0;
            b.wr    = wr;
            b.hprot = hp;
            exp_beat_q.push_back(b);
            if (wr && i < commit) ref_mem[la * W + i] = line[i*WB +: WB];
            rl[i*WB +: WB] = ref_rd(la * W + i);
        end
        if (!wr) exp_rsp_q.push_back(rl);
        llc_mem_req_valid       = 1'b1;
        llc_mem_req_data_hwrite = wr;
        llc_mem_req_data_hsize  = 3'($urandom);
        llc_mem_req_data_hprot  = hp;
        llc_mem_req_data_addr   = la[27:0];
        llc_mem_req_data_line   = line;
        ok = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (llc_mem_req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("req_accept", ok, 1'b1);
        req_cycle = cyc;
        @(posedge clk);
        #1;
        llc_mem_req_valid     = 1'b0;
        llc_mem_req_data_addr = 28'($urandom);
        llc_mem_req_data_line = rand_line();
        if (wr && commit == W) wr_model++;
        if (!wr) rd_model++;
    endtask

    task automatic wait_drain();
        bit ok = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (llc_mem_req_ready && exp_beat_q.size() == 0 && exp_rsp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        check("drain", ok, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        exp_beat_q.delete();
        exp_rsp_q.delete();
        rd_q.delete();
        wr_model = 0;
        rd_model = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_wr_cnt"}, llc_mem_wr_cnt, STATS ? 32'(wr_model) : 32'd0);
        check({tag, "_rd_cnt"}, llc_mem_rd_cnt, STATS ? 32'(rd_model) : 32'd0);
    endtask

    initial begin
        int  n;
        bit  ok;
        rst                     = 1'b1;
        llc_mem_req_valid       = 1'b0;
        llc_mem_req_data_hwrite = 1'b0;
        llc_mem_req_data_hsize  = '0;
        llc_mem_req_data_hprot  = '0;
        llc_mem_req_data_addr   = '0;
        llc_mem_req_data_line   = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_req_ready",   llc_mem_req_ready, 1'b1);
        check("rst_beat_valid",  mem_beat_valid, 1'b0);
        check("rst_rsp_valid",   llc_mem_rsp_valid, 1'b0);
        check("rst_rdata_ready", mem_rdata_ready, 1'b0);
        check("rst_rsp_line",    llc_mem_rsp_data_line, 256'd0);
        check_counters("rst");
        @(posedge clk);
        #1;

        // Directed write of line 0x10 with every beat accepted at once.
        do_req(1'b1, 32'h10,
               {64'hDDDD_0000_0000_000D, 64'hCCCC_0000_0000_000C,
                64'hBBBB_0000_0000_000B, 64'hAAAA_0000_0000_000A}, 2'b01, W);
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (llc_mem_req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("wr_latency", ok ? cyc - req_cycle : -1, W + 1);
        check("wr_no_rsp", exp_rsp_q.size(), 0);
        wait_drain();

        // Directed read of line 1 from zero-wait memory.
        for (int i = 0; i < W; i++) begin
            mem[4 + i]     = 64'h11 * (i + 1);
            ref_mem[4 + i] = 64'h11 * (i + 1);
        end
        do_req(1'b0, 32'h1, rand_line(), 2'b10, W);
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (llc_mem_rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check("rd_latency", ok ? cyc - req_cycle : -1, W + 2);
        check("rd_line_known", llc_mem_rsp_data_line,
              {64'h44, 64'h33, 64'h22, 64'h11});
        wait_drain();

        // Toggling beat ready, and the response held off for 5 cycles.
        beat_mode = 2;
        rsp_hold  = 5;
        do_req(1'b0, 32'h3, rand_line(), 2'b11, W);
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (llc_mem_rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        n = 0;
        while (ok && llc_mem_rsp_valid && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("rsp_hold_cycles", n, 6);
        check("idle_after_rsp", llc_mem_req_ready, 1'b1);
        beat_mode = 0;
        wait_drain();

        // Read data that arrives while idle must be ignored.
        spur = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("spur_req_ready", llc_mem_req_ready, 1'b1);
            check("spur_rdata_ready", mem_rdata_ready, 1'b0);
        end
        @(posedge clk);
        #1;
        spur = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_req(1'b0, 32'h5, rand_line(), 2'b00, W);
        wait_drain();

        // Reset after the second write beat is accepted.
        n = beat_hs_cnt;
        do_req(1'b1, 32'h6, rand_line(), 2'b01, 2);
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            #1;
            if (beat_hs_cnt >= n + 2) begin
                ok = 1'b1;
                break;
            end
        end
        check("abort_two_beats", ok, 1'b1);
        @(posedge clk);
        #1;
        pulse_reset();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("abort_req_ready", llc_mem_req_ready, 1'b1);
            check("abort_no_beat", mem_beat_valid, 1'b0);
        end
        @(posedge clk);
        #1;
        do_req(1'b0, 32'h6, rand_line(), 2'b10, W);
        wait_drain();

        // Line counters: 3 writes then 2 reads.
        pulse_reset();
        for (int k = 0; k < 3; k++) do_req(1'b1, $urandom_range(0, 7), rand_line(), 2'($urandom), W);
        for (int k = 0; k < 2; k++) do_req(1'b0, $urandom_range(0, 7), rand_line(), 2'($urandom), W);
        wait_drain();
        check_counters("stats");

        // Random traffic with random stalls on every channel.
        rand_mode = 1'b1;
        beat_mode = 1;
        for (int k = 0; k < 40; k++)
            do_req(1'($urandom), $urandom_range(0, 7), rand_line(), 2'($urandom), W);
        wait_drain();
        check_counters("random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
